sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
- REQ-001 Parameter TIMEOUT, default 255, maximum BUSY cycles before an access is aborted; legal range 2..255, held in an 8-bit counter.
- REQ-002 Port: clk, input, 1, single clock; all state updates on the rising edge.
- REQ-003 Port: rst, input, 1, reset, asynchronous, active-low.
- REQ-004 Ports pN_r_en / pN_w_en, input, 1 each (N=0,1), read/write request from requester N; must be held until pN_ack.
- REQ-005 Ports pN_addr, input, 32, byte address, held stable with the request.
- REQ-006 Ports pN_wdata, input, 32, write data, held stable with the request.
- REQ-007 Ports pN_ack, output, 1, one-cycle completion pulse to requester N.
- REQ-008 Ports pN_err, output, 1, valid with pN_ack, high when the access timed out.
- REQ-009 Ports pN_stall, output, 1, pipeline freeze, equal to (pN_r_en|pN_w_en) & ~pN_ack.
- REQ-010 Ports pN_rdata, output, 32, last read word returned to requester N.
- REQ-011 Ports sram_r_en / sram_w_en, output, 1 each, to SRAM controller MEM_R_EN/MEM_W_EN.
- REQ-012 Port sram_addr, output, 32, to controller address.
- REQ-013 Port sram_wdata, output, 32, to controller writeData.
- REQ-014 Port sram_ready, input, 1, controller ready; low while an access is in progress.
- REQ-015 Port sram_rdata, input, 64, controller readData, one 64-bit line.

Function
- REQ-016 FSM SHALL have states IDLE, BUSY and ACK.
- REQ-017 IDLE: SHALL grant when any request is pending, latch the winner's op, addr and wdata into internal registers, clear the timeout counter, and enter BUSY next cycle.
- REQ-018 Arbitration SHALL be round-robin: with both requesting, the port not granted last wins; a lone requester always wins.
- REQ-019 A port asserting r_en and w_en together SHALL be treated as a write.
- REQ-020 BUSY: sram_r_en/sram_w_en SHALL be driven from the latched op and sram_addr/sram_wdata from the latched registers; all are driven only in BUSY.
- REQ-021 BUSY: sram_ready=1 SHALL mark completion; the arbiter captures the data and enters ACK. The controller drops ready in the same cycle its enable rises.
- REQ-022 Read capture: when addr[2]=1, sram_rdata[63:32] SHALL be written to the granted port's rdata register; otherwise sram_rdata[31:0]. Writes leave rdata unchanged.
- REQ-023 The timeout counter SHALL increment each BUSY cycle; on reaching TIMEOUT without ready, the access is abandoned, err is set, and the FSM enters ACK.
- REQ-024 ACK: the granted port's pN_ack SHALL be 1 and pN_err SHALL be valid for exactly one cycle; last_grant SHALL be updated; the next state is IDLE.
- REQ-025 Latency: a request seen in IDLE at cycle t with ready at t+k (k≥1) SHALL give ack at t+k+1; the next grant SHALL come no earlier than t+k+2.
- REQ-026 Requests arriving during BUSY or ACK SHALL wait; no request is dropped.
- REQ-027 Starvation bound: a pending request SHALL be granted after at most one other transaction.
- REQ-028 pN_rdata SHALL hold its value until the next completed read for that port; a timed-out read leaves it unchanged.

Reset
- REQ-029 On rst=0, the FSM SHALL go to IDLE immediately (asynchronously).
- REQ-030 On rst=0, all sram_* outputs, pN_ack and pN_err SHALL be 0.
- REQ-031 On rst=0, pN_rdata and the latched registers SHALL be 0, the counter 0, and last_grant=1 (port 0 wins the first tie).
- REQ-032 Reset asserted mid-BUSY SHALL abort the access with no ack issued; requesters must re-request after reset.

Structure
- REQ-033 The state enum, port-index constants and default TIMEOUT SHALL live in shared package arm_mem_pkg.
- REQ-034 The round-robin grant logic SHALL be one sub-module, rr_arbiter2 (inputs req[1:0], last_grant; output grant), combinational.

Verification
- REQ-035 p0 read of addr 0x4 with sram_rdata=0xAAAA_BBBB_1111_2222 and ready after 3 cycles -> p0_ack 1 cycle later, p0_rdata=0xAAAA_BBBB, p0_err=0.
- REQ-036 p0 and p1 requesting simultaneously from reset -> p0 granted first, then p1; a repeated tie -> p0 again after p1.
- REQ-037 p1 write of 0x1234_5678 to 0x10 -> sram_w_en=1, sram_addr=0x10, sram_wdata=0x1234_5678 held through BUSY; p1_rdata unchanged.
- REQ-038 sram_ready held low with TIMEOUT=4 -> ack with err=1 after 4 BUSY cycles; sram enables low in ACK; the next request is served normally.
- REQ-039 rst asserted in the 2nd BUSY cycle -> sram enables 0 in the same cycle, no ack, all outputs at reset values.
- REQ-040 p0 r_en+w_en together -> performed as a write; p0_stall high until ack cycle, then low.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared constants for the two-port SRAM arbiter:
// FSM state codes, port indices and the default access timeout.
package arm_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam logic [7:0] TIMEOUT_DEF = 8'd255;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the port not granted last wins.
// Output is the index of the winning port.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    unique case (req)
      2'b11:   grant = ~last_grant;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller between two requesters.
// IDLE grants and latches, BUSY drives the controller, ACK pulses completion.
module sram_arbiter
  import arm_mem_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_r_en,
  input  logic        p0_w_en,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic        p0_stall,
  output logic [31:0] p0_rdata,
  input  logic        p1_r_en,
  input  logic        p1_w_en,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic        p1_stall,
  output logic [31:0] p1_rdata,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_ready,
  input  logic [63:0] sram_rdata
);

  logic [1:0]  r_state;
  logic        r_gnt;
  logic        r_last;
  logic        r_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic [1:0]  w_req;
  logic        w_grant;
  logic        w_busy;
  logic        w_ack;
  logic [31:0] w_word;
  logic [7:0]  w_cnt_nx;

  assign w_req    = {p1_r_en | p1_w_en, p0_r_en | p0_w_en};
  assign w_busy   = (r_state == ST_BUSY);
  assign w_ack    = (r_state == ST_ACK);
  assign w_word   = r_addr[2] ? sram_rdata[63:32] : sram_rdata[31:0];
  assign w_cnt_nx = r_cnt + 8'd1;

  rr_arbiter2 u_rr (
    .req        (w_req),
    .last_grant (r_last),
    .grant      (w_grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= P0;
      r_last   <= P1;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_gnt   <= w_grant;
            // r_en with w_en together is a write
            r_wr    <= (w_grant == P1) ? p1_w_en : p0_w_en;
            r_addr  <= (w_grant == P1) ? p1_addr : p0_addr;
            r_wdata <= (w_grant == P1) ? p1_wdata : p0_wdata;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_cnt <= w_cnt_nx;
          if (sram_ready) begin
            if (!r_wr) begin
              if (r_gnt == P1) r_rdata1 <= w_word;
              else             r_rdata0 <= w_word;
            end
            r_state <= ST_ACK;
          end else if (w_cnt_nx == TIMEOUT) begin
            r_err   <= 1'b1;
            r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_last  <= r_gnt;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sram_r_en  = w_busy & ~r_wr;
  assign sram_w_en  = w_busy & r_wr;
  assign sram_addr  = w_busy ? r_addr : '0;
  assign sram_wdata = w_busy ? r_wdata : '0;

  assign p0_ack   = w_ack & (r_gnt == P0);
  assign p1_ack   = w_ack & (r_gnt == P1);
  assign p0_err   = p0_ack & r_err;
  assign p1_err   = p1_ack & r_err;
  assign p0_stall = w_req[0] & ~p0_ack;
  assign p1_stall = w_req[1] & ~p1_ack;
  assign p0_rdata = r_rdata0;
  assign p1_rdata = r_rdata1;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: vector table of single-port accesses
// plus hand sequences for tie arbitration and reset during BUSY.
module tb_sram_arbiter;

  localparam logic [7:0] TO = 8'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p0_r_en = 1'b0, p0_w_en = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic        p0_ack, p0_err, p0_stall;
  logic [31:0] p0_rdata;
  logic        p1_r_en = 1'b0, p1_w_en = 1'b0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic        p1_ack, p1_err, p1_stall;
  logic [31:0] p1_rdata;
  logic        sram_r_en, sram_w_en;
  logic [31:0] sram_addr, sram_wdata;
  logic        sram_ready = 1'b0;
  logic [63:0] sram_rdata = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .p0_r_en(p0_r_en), .p0_w_en(p0_w_en),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err),
    .p0_stall(p0_stall), .p0_rdata(p0_rdata),
    .p1_r_en(p1_r_en), .p1_w_en(p1_w_en),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err),
    .p1_stall(p1_stall), .p1_rdata(p1_rdata),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_ready(sram_ready), .sram_rdata(sram_rdata)
  );

  typedef struct {
    logic        port;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [63:0] rd64;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic port, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (port) begin
      p1_r_en = rd; p1_w_en = wr; p1_addr = addr; p1_wdata = wd;
    end else begin
      p0_r_en = rd; p0_w_en = wr; p0_addr = addr; p0_wdata = wd;
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    bit   done;
    int   lat;
    int   exp_lat;
    v = vecs[idx];
    done = 0;
    lat = 0;
    exp_lat = (v.dly == 0) ? int'(TO) + 1 : v.dly + 1;
    @(negedge clk);
    drive(v.port, v.rd, v.wr, v.addr, v.wdata);
    sram_rdata = v.rd64;
    sram_ready = 1'b0;
    while (!done && lat < 12) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (v.port ? p1_ack : p0_ack) done = 1;
      else begin
        if (lat == 1) begin
          chk($sformatf("v%0d w_en", idx), sram_w_en, v.wr);
          chk($sformatf("v%0d r_en", idx), sram_r_en, !v.wr);
          chk($sformatf("v%0d addr", idx), sram_addr, v.addr);
          if (v.wr)
            chk($sformatf("v%0d wdata", idx), sram_wdata, v.wdata);
          chk($sformatf("v%0d stall", idx),
              v.port ? p1_stall : p0_stall, 1);
        end
        sram_ready = (v.dly != 0 && lat == v.dly);
      end
    end
    sram_ready = 1'b0;
    chk($sformatf("v%0d ack_seen", idx), done, 1);
    chk($sformatf("v%0d latency", idx), lat, exp_lat);
    chk($sformatf("v%0d err", idx), v.port ? p1_err : p0_err, v.exp_err);
    chk($sformatf("v%0d rdata", idx),
        v.port ? p1_rdata : p0_rdata, v.exp_rdata);
    chk($sformatf("v%0d stall_ack", idx),
        v.port ? p1_stall : p0_stall, 0);
    chk($sformatf("v%0d other_ack", idx), v.port ? p0_ack : p1_ack, 0);
    chk($sformatf("v%0d en_in_ack", idx), {sram_r_en, sram_w_en}, 0);
    drive(v.port, 1'b0, 1'b0, '0, '0);
  endtask

  // both ports read together; controller answers in the first BUSY cycle
  task automatic tie_pair(output int a, output int b);
    int n;
    bit d0, d1;
    n = 0; d0 = 0; d1 = 0; a = -1; b = -1;
    @(negedge clk);
    sram_rdata = '0;
    drive(1'b0, 1'b1, 1'b0, 32'h0, '0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, '0);
    for (int c = 0; c < 20 && !(d0 && d1); c++) begin
      @(posedge clk);
      @(negedge clk);
      sram_ready = sram_r_en | sram_w_en;
      if (p0_ack && !d0) begin
        d0 = 1; p0_r_en = 1'b0;
        if (n == 0) a = 0; else b = 0;
        n++;
      end
      if (p1_ack && !d1) begin
        d1 = 1; p1_r_en = 1'b0;
        if (n == 0) a = 1; else b = 1;
        n++;
      end
    end
    sram_ready = 1'b0;
    p0_r_en = 1'b0;
    p1_r_en = 1'b0;
  endtask

  initial begin
    int f, s;
    vecs[0] = '{0, 1, 0, 32'h4,  32'h0, 3, 64'hAAAA_BBBB_1111_2222,
                32'hAAAA_BBBB, 0};
    vecs[1] = '{0, 1, 0, 32'h8,  32'h0, 1, 64'h5555_6666_7777_8888,
                32'h7777_8888, 0};
    vecs[2] = '{1, 0, 1, 32'h10, 32'h1234_5678, 2, 64'hFFFF_FFFF_FFFF_FFFF,
                32'h0, 0};
    vecs[3] = '{1, 1, 0, 32'h1C, 32'h0, 1, 64'hDEAD_BEEF_CAFE_F00D,
                32'hDEAD_BEEF, 0};
    vecs[4] = '{1, 1, 0, 32'h18, 32'h0, 0, 64'h1111_1111_2222_2222,
                32'hDEAD_BEEF, 1};
    vecs[5] = '{0, 1, 1, 32'h20, 32'hA5A5_A5A5, 2, 64'h9999_9999_9999_9999,
                32'h7777_8888, 0};
    vecs[6] = '{0, 0, 1, 32'h24, 32'h5A5A_5A5A, 0, 64'h3333_3333_3333_3333,
                32'h7777_8888, 1};
    vecs[7] = '{0, 1, 0, 32'h0,  32'h0, 1, 64'h0123_4567_89AB_CDEF,
                32'h89AB_CDEF, 0};
    vecs[8] = '{1, 1, 0, 32'h4,  32'h0, 2, 64'hFEED_FACE_0000_0001,
                32'hFEED_FACE, 0};

    repeat (3) @(negedge clk);
    chk("rst sram_en", {sram_r_en, sram_w_en}, 0);
    chk("rst sram_addr", sram_addr, 0);
    chk("rst sram_wdata", sram_wdata, 0);
    chk("rst ack", {p0_ack, p1_ack}, 0);
    chk("rst err", {p0_err, p1_err}, 0);
    chk("rst p0_rdata", p0_rdata, 0);
    chk("rst p1_rdata", p1_rdata, 0);
    rst = 1'b1;

    tie_pair(f, s);
    chk("tie1 first", f, 0);
    chk("tie1 second", s, 1);
    tie_pair(f, s);
    chk("tie2 first", f, 0);
    chk("tie2 second", s, 1);

    for (int i = 0; i < 8; i++) run_vec(i);

    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h4, '0);
    sram_rdata = 64'hCCCC_CCCC_DDDD_DDDD;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    chk("busy2 r_en", sram_r_en, 1);
    rst = 1'b0;
    #1;
    chk("mid rst en", {sram_r_en, sram_w_en}, 0);
    chk("mid rst addr", sram_addr, 0);
    chk("mid rst ack", {p0_ack, p1_ack}, 0);
    chk("mid rst p0_rdata", p0_rdata, 0);
    chk("mid rst p1_rdata", p1_rdata, 0);
    chk("mid rst stall", p0_stall, 1);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst hold ack%0d", c), {p0_ack, p1_ack}, 0);
    end
    rst = 1'b1;
    run_vec(8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
